// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: FSM state encoding, element and gap
// lengths in Morse units, the {len, pat} code-record layout, and a helper that
// maps an element bit (1 = dash) to its mark length in units.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_EGAP,
    ST_CGAP
  } state_t;

  localparam logic [2:0] UNITS_DOT  = 3'd1;
  localparam logic [2:0] UNITS_DASH = 3'd3;
  localparam logic [2:0] UNITS_EGAP = 3'd1;
  localparam logic [2:0] UNITS_CGAP = 3'd3;
  localparam logic [2:0] UNITS_WGAP = 3'd4;

  // pat bit i is element i (first element in the LSB), 1 = dash.
  // len = 0 marks an unsupported character.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  function automatic logic [2:0] mark_units(input logic dash);
    return dash ? UNITS_DASH : UNITS_DOT;
  endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Character handshake for the Morse keyer.
//   x       : ASCII character, valid with x_valid
//   x_valid : character present (from producer)
//   x_ready : keyer can accept a character (from keyer)
// master = character producer, slave = keyer.
interface morse_keyer_if;
  logic [7:0] x;
  logic       x_valid;
  logic       x_ready;

  modport master (output x, output x_valid, input  x_ready);
  modport slave  (input  x, input  x_valid, output x_ready);
endinterface

// File: rtl/morse_lut.sv
// Combinational ASCII -> Morse code-record lookup.
//   i_x     : ASCII character
//   o_code  : {len, pat}; len = 0 for anything outside A-Z, a-z, 0-9
//   o_space : i_x is the space character (0x20)
// Lower-case letters are folded to upper case before the lookup.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0] i_x,
  output code_t      o_code,
  output logic       o_space
);

  logic [7:0] w_up;

  always_comb begin
    w_up = i_x;
    if (i_x >= 8'h61 && i_x <= 8'h7A) w_up = i_x - 8'h20;
    o_space = (i_x == 8'h20);
    o_code  = '0;
    case (w_up)
      8'h41: o_code = {3'd2, 5'b00010}; // A .-
      8'h42: o_code = {3'd4, 5'b00001}; // B -...
      8'h43: o_code = {3'd4, 5'b00101}; // C -.-.
      8'h44: o_code = {3'd3, 5'b00001}; // D -..
      8'h45: o_code = {3'd1, 5'b00000}; // E .
      8'h46: o_code = {3'd4, 5'b00100}; // F ..-.
      8'h47: o_code = {3'd3, 5'b00011}; // G --.
      8'h48: o_code = {3'd4, 5'b00000}; // H ....
      8'h49: o_code = {3'd2, 5'b00000}; // I ..
      8'h4A: o_code = {3'd4, 5'b01110}; // J .---
      8'h4B: o_code = {3'd3, 5'b00101}; // K -.-
      8'h4C: o_code = {3'd4, 5'b00010}; // L .-..
      8'h4D: o_code = {3'd2, 5'b00011}; // M --
      8'h4E: o_code = {3'd2, 5'b00001}; // N -.
      8'h4F: o_code = {3'd3, 5'b00111}; // O ---
      8'h50: o_code = {3'd4, 5'b00110}; // P .--.
      8'h51: o_code = {3'd4, 5'b01011}; // Q --.-
      8'h52: o_code = {3'd3, 5'b00010}; // R .-.
      8'h53: o_code = {3'd3, 5'b00000}; // S ...
      8'h54: o_code = {3'd1, 5'b00001}; // T -
      8'h55: o_code = {3'd3, 5'b00100}; // U ..-
      8'h56: o_code = {3'd4, 5'b01000}; // V ...-
      8'h57: o_code = {3'd3, 5'b00110}; // W .--
      8'h58: o_code = {3'd4, 5'b01001}; // X -..-
      8'h59: o_code = {3'd4, 5'b01101}; // Y -.--
      8'h5A: o_code = {3'd4, 5'b00011}; // Z --..
      8'h30: o_code = {3'd5, 5'b11111}; // 0 -----
      8'h31: o_code = {3'd5, 5'b11110}; // 1 .----
      8'h32: o_code = {3'd5, 5'b11100}; // 2 ..---
      8'h33: o_code = {3'd5, 5'b11000}; // 3 ...--
      8'h34: o_code = {3'd5, 5'b10000}; // 4 ....-
      8'h35: o_code = {3'd5, 5'b00000}; // 5 .....
      8'h36: o_code = {3'd5, 5'b00001}; // 6 -....
      8'h37: o_code = {3'd5, 5'b00011}; // 7 --...
      8'h38: o_code = {3'd5, 5'b00111}; // 8 ---..
      8'h39: o_code = {3'd5, 5'b01111}; // 9 ----.
      default: o_code = '0;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Timed Morse transmitter. Accepts one ASCII character per ready/valid
// handshake and keys its dot/dash pattern with standard element timing,
// UNIT_CYCLES clock cycles per Morse unit.
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   s_if : character handshake (slave side: x, x_valid in; x_ready out)
//   key  : keying line, 1 = tone on
//   busy : a character or its trailing gap is being emitted
//   err  : one-cycle pulse after an unsupported character is accepted
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  morse_keyer_if.slave   s_if,
  output logic           key,
  output logic           busy,
  output logic           err
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cyc;
  logic [2:0]         r_units;
  logic [2:0]         r_idx;
  code_t              r_code;
  logic               r_key;
  logic               r_busy;
  logic               r_err;

  code_t              w_code;
  logic               w_space;
  logic               w_wrap;
  logic               w_last;
  logic [2:0]         w_next_idx;

  morse_lut u_lut (
    .i_x     (s_if.x),
    .o_code  (w_code),
    .o_space (w_space)
  );

  assign w_wrap     = (r_cyc == CNT_W'(UNIT_CYCLES - 1));
  assign w_last     = w_wrap && (r_units == 3'd1);
  assign w_next_idx = r_idx + 3'd1;

  assign s_if.x_ready = (r_state == ST_IDLE);
  assign key          = r_key;
  assign busy         = r_busy;
  assign err          = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_units <= '0;
      r_idx   <= '0;
      r_code  <= '0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;

      // Common unit timing for every non-IDLE state; a state exit below
      // overrides the decremented unit count with the next state's load.
      if (r_state != ST_IDLE) begin
        r_cyc <= w_wrap ? '0 : r_cyc + CNT_W'(1);
        if (w_wrap) r_units <= r_units - 3'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (s_if.x_valid) begin
            if (w_space) begin
              r_state <= ST_CGAP;
              r_units <= UNITS_WGAP;
              r_busy  <= 1'b1;
            end else if (w_code.len != 3'd0) begin
              r_code  <= w_code;
              r_idx   <= '0;
              r_state <= ST_MARK;
              r_units <= mark_units(w_code.pat[0]);
              r_key   <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_MARK: begin
          if (w_last) begin
            r_key <= 1'b0;
            if (w_next_idx < r_code.len) begin
              r_state <= ST_EGAP;
              r_units <= UNITS_EGAP;
              r_idx   <= w_next_idx;
            end else begin
              r_state <= ST_CGAP;
              r_units <= UNITS_CGAP;
            end
          end
        end
        ST_EGAP: begin
          if (w_last) begin
            r_state <= ST_MARK;
            r_units <= mark_units(r_code.pat[r_idx]);
            r_key   <= 1'b1;
          end
        end
        ST_CGAP: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_units <= '0;
            r_idx   <= '0;
            r_code  <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
module tb_morse_keyer;

  typedef struct packed {
    logic key;
    logic busy;
    logic ready;
    logic err;
  } frame_t;

  typedef frame_t fq_t[$];

  // kind: 0 = keyed character, 1 = space, 2 = unsupported
  typedef struct {
    logic [7:0] ch;
    string      code;
    int         kind;
  } vec_t;

  logic clk;
  logic rst;
  logic key4, busy4, err4;
  logic key1, busy1, err1;

  int checks = 0;
  int errors = 0;

  frame_t q4[$];
  frame_t q1[$];

  vec_t tbl[17];

  morse_keyer_if if4();
  morse_keyer_if if1();

  morse_keyer #(.UNIT_CYCLES(4), .CNT_W(16)) u4 (
    .clk  (clk),
    .rst  (rst),
    .s_if (if4),
    .key  (key4),
    .busy (busy4),
    .err  (err4)
  );

  morse_keyer #(.UNIT_CYCLES(1), .CNT_W(4)) u1 (
    .clk  (clk),
    .rst  (rst),
    .s_if (if1),
    .key  (key1),
    .busy (busy1),
    .err  (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic frame_t mk(input logic k, input logic b, input logic r, input logic e);
    frame_t f;
    f.key = k; f.busy = b; f.ready = r; f.err = e;
    return f;
  endfunction

  // Per-cycle expectation from the handshake edge onward, ending with the
  // IDLE cycle in which x_ready is back.
  task automatic build(input string code, input int kind, input int unsigned u, output fq_t f);
    int unsigned n;
    f = {};
    if (kind == 2) begin
      f.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
      f.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    end else if (kind == 1) begin
      for (int unsigned i = 0; i < 4 * u; i++) f.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      f.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    end else begin
      for (int i = 0; i < code.len(); i++) begin
        n = (code[i] == 8'h2D) ? 3 * u : u;
        for (int unsigned j = 0; j < n; j++) f.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        if (i < code.len() - 1)
          for (int unsigned j = 0; j < u; j++) f.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      end
      for (int unsigned j = 0; j < 3 * u; j++) f.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      f.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  function automatic string code_of(input logic [7:0] c);
    case (c)
      8'h53:   return "...";
      8'h4F:   return "---";
      8'h35:   return ".....";
      8'h45:   return ".";
      default: return "";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_x(input int which, input logic [7:0] c, input logic v);
    if (which == 4) begin if4.x = c; if4.x_valid = v; end
    else            begin if1.x = c; if1.x_valid = v; end
  endtask

  function automatic logic get_ready(input int which);
    return (which == 4) ? if4.x_ready : if1.x_ready;
  endfunction

  task automatic push(input int which, input fq_t f);
    foreach (f[i]) begin
      if (which == 4) q4.push_back(f[i]);
      else            q1.push_back(f[i]);
    end
  endtask

  task automatic wait_empty(input int which);
    int n;
    n = 0;
    while (((which == 4) ? q4.size() : q1.size()) > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain%0d: scoreboard not drained after %0d cycles", which, n);
      if (which == 4) q4 = {}; else q1 = {};
    end
  endtask

  // Single character with a one-cycle valid pulse.
  task automatic send4(input vec_t v);
    fq_t f;
    @(negedge clk);
    set_x(4, v.ch, 1'b1);
    chk($sformatf("ready_before_%0h", v.ch), {31'd0, if4.x_ready}, 32'd1);
    @(posedge clk);
    #1;
    set_x(4, 8'h00, 1'b0);
    build(v.code, v.kind, 4, f);
    push(4, f);
    wait_empty(4);
  endtask

  // Characters streamed with x_valid held high throughout.
  task automatic stream(input int which, input string s, input int unsigned u);
    fq_t f;
    int n;
    logic [7:0] c;
    for (int k = 0; k < s.len(); k++) begin
      c = s[k];
      set_x(which, c, 1'b1);
      n = 0;
      @(negedge clk);
      while (!get_ready(which) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 5000) begin
        checks++;
        errors++;
        $display("FAIL stream%0d: x_ready never rose for char %0h", which, c);
        break;
      end
      @(posedge clk);
      #1;
      build(code_of(c), (c == 8'h20) ? 1 : 0, u, f);
      push(which, f);
    end
    set_x(which, 8'h00, 1'b0);
    wait_empty(which);
  endtask

  always @(negedge clk) begin
    frame_t e, a;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      a = mk(key4, busy4, if4.x_ready, err4);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL frame4 t=%0t: key/busy/ready/err got %b, expected %b", $time, a, e);
      end
    end
  end

  always @(negedge clk) begin
    frame_t e, a;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = mk(key1, busy1, if1.x_ready, err1);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL frame1 t=%0t: key/busy/ready/err got %b, expected %b", $time, a, e);
      end
    end
  end

  initial begin
    tbl[0]  = '{8'h45, ".",     0};
    tbl[1]  = '{8'h41, ".-",    0};
    tbl[2]  = '{8'h61, ".-",    0};
    tbl[3]  = '{8'h51, "--.-",  0};
    tbl[4]  = '{8'h4A, ".---",  0};
    tbl[5]  = '{8'h7A, "--..",  0};
    tbl[6]  = '{8'h30, "-----", 0};
    tbl[7]  = '{8'h39, "----.", 0};
    tbl[8]  = '{8'h35, ".....", 0};
    tbl[9]  = '{8'h20, "",      1};
    tbl[10] = '{8'h23, "",      2};
    tbl[11] = '{8'h40, "",      2};
    tbl[12] = '{8'h5B, "",      2};
    tbl[13] = '{8'h60, "",      2};
    tbl[14] = '{8'h7B, "",      2};
    tbl[15] = '{8'h2F, "",      2};
    tbl[16] = '{8'h3A, "",      2};

    rst = 1'b1;
    set_x(4, 8'h00, 1'b0);
    set_x(1, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key4",   {31'd0, key4},        32'd0);
    chk("rst_busy4",  {31'd0, busy4},       32'd0);
    chk("rst_err4",   {31'd0, err4},        32'd0);
    chk("rst_ready4", {31'd0, if4.x_ready}, 32'd1);
    chk("rst_key1",   {31'd0, key1},        32'd0);
    chk("rst_ready1", {31'd0, if1.x_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) send4(tbl[i]);

    // '5' then space with valid held: 12 + 1 IDLE + 16 key-low cycles after the last dot.
    stream(4, "5 ", 4);

    // Reset in the middle of the dash of 'T'.
    @(negedge clk);
    set_x(4, 8'h54, 1'b1);
    @(posedge clk);
    #1;
    set_x(4, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    chk("t_dash_key", {31'd0, key4}, 32'd1);
    chk("t_dash_ready", {31'd0, if4.x_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t_rst_key",   {31'd0, key4},        32'd0);
    chk("t_rst_ready", {31'd0, if4.x_ready}, 32'd1);
    chk("t_rst_busy",  {31'd0, busy4},       32'd0);
    @(negedge clk);
    rst = 1'b0;
    send4(tbl[0]);

    // UNIT_CYCLES = 1 build, "SOS" streamed back to back.
    stream(1, "SOS", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
